accel_sequencer: RTL and testbench

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

---
 rtl/accel_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_accel_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_sequencer.sv
// Accelerometer bring-up and polling sequencer in front of a generic SPI master.
// Optional watchdog: define SEQ_TIMEOUT_EN to halt on a stalled SPI handshake.
module accel_sequencer #(
  parameter int         N_AXES         = 3,
  parameter logic [7:0] WHOAMI_VAL     = 8'h33,
  parameter logic [7:0] CTRL1_VAL      = 8'h77,
  parameter int         LED_AXIS       = 0,
  parameter int         POLL_GAP       = 16,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk_in,
  input  logic                  nrst,
  output logic [31:0]           spi_mosi_data,
  input  logic [31:0]           spi_miso_data,
  output logic [5:0]            spi_nbits,
  output logic                  spi_request,
  input  logic                  spi_ready,
  output logic [16*N_AXES-1:0]  axis_data,
  output logic                  sweep_valid,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [7:0]            led_out
);

  typedef enum logic [3:0] {
    S_WHOAMI, S_WHOAMI_WAIT, S_INIT, S_INIT_WAIT,
    S_READ, S_READ_WAIT, S_LEDOUT, S_GAP, S_HALT
  } state_t;

  localparam logic [1:0]  LAST_AXIS = 2'(N_AXES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(POLL_GAP);

  state_t      state;
  logic [1:0]  init_idx;
  logic [1:0]  axis_idx;
  logic [15:0] gap_cnt;
  logic [31:0] req_frame;
  logic [5:0]  req_nbits;
  logic        is_req;
  logic        req_start;
  logic        req_taken;
  logic        tmo_hit;
  logic [7:0]  led_hi;
  logic        unused_miso;

  // A request is raised only while the master reports idle, and is withdrawn
  // once the master acknowledges by dropping spi_ready.
  assign is_req    = (state == S_WHOAMI) || (state == S_INIT) || (state == S_READ);
  assign req_start = is_req && !spi_request && spi_ready;
  assign req_taken = is_req && spi_request && !spi_ready;
  assign led_hi    = axis_data[16*LED_AXIS+8 +: 8];
  assign unused_miso = ^spi_miso_data[31:16];

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    req_frame = 32'h0;
    req_nbits = 6'd15;
    case (state)
      S_WHOAMI: req_frame = 32'h0000_8F00;
      S_INIT: begin
        case (init_idx)
          2'd0:    req_frame = {16'h0, 8'h20, CTRL1_VAL};
          2'd1:    req_frame = 32'h0000_1FC0;
          default: req_frame = 32'h0000_2388;
        endcase
      end
      S_READ: begin
        req_frame = {8'h00, 8'hC0 | (8'h28 + {5'b0, axis_idx, 1'b0}), 16'h0000};
        req_nbits = 6'd23;
      end
      default: ;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  state_t      tmo_state;
  logic [31:0] tmo_cnt;
  logic        timed;

  assign timed = is_req || (state == S_WHOAMI_WAIT) || (state == S_INIT_WAIT) ||
                 (state == S_READ_WAIT);

  // tmo_cnt holds the number of cycles spent in the current state.
  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      tmo_state <= S_WHOAMI;
      tmo_cnt   <= '0;
    end else begin
      tmo_state <= state;
      if (!timed)                  tmo_cnt <= '0;
      else if (state != tmo_state) tmo_cnt <= 32'd1;
      else                         tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = timed && (state == tmo_state) &&
                   (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      state         <= S_WHOAMI;
      init_idx      <= '0;
      axis_idx      <= '0;
      gap_cnt       <= '0;
      spi_request   <= 1'b0;
      spi_mosi_data <= '0;
      spi_nbits     <= '0;
      axis_data     <= '0;
      sweep_valid   <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      led_out       <= 8'hFF;
    end else begin
      sweep_valid <= 1'b0;
      if (req_start) begin
        spi_request   <= 1'b1;
        spi_mosi_data <= req_frame;
        spi_nbits     <= req_nbits;
      end else if (req_taken) begin
        spi_request <= 1'b0;
      end

      case (state)
        S_WHOAMI: begin
          led_out <= 8'hFE;
          if (req_taken) state <= S_WHOAMI_WAIT;
        end
        S_WHOAMI_WAIT: begin
          if (spi_ready) begin
            if (spi_miso_data[7:0] != WHOAMI_VAL) begin
              state    <= S_HALT;
              error    <= 1'b1;
              err_code <= 2'd1;
              led_out  <= 8'h00;
            end else begin
              state    <= S_INIT;
              init_idx <= 2'd0;
            end
          end
        end
        S_INIT: begin
          led_out <= ~(8'h02 << init_idx);
          if (req_taken) state <= S_INIT_WAIT;
        end
        S_INIT_WAIT: begin
          if (spi_ready) begin
            if (init_idx == 2'd2) begin
              state    <= S_READ;
              axis_idx <= 2'd0;
            end else begin
              init_idx <= init_idx + 2'd1;
              state    <= S_INIT;
            end
          end
        end
        S_READ: begin
          if (req_taken) state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (spi_ready) begin
            // Sensor returns the low byte first; store as {H, L}.
            for (int a = 0; a < N_AXES; a++) begin
              if (axis_idx == 2'(a))
                axis_data[16*a +: 16] <= {spi_miso_data[7:0], spi_miso_data[15:8]};
            end
            if (axis_idx == LAST_AXIS) begin
              state <= S_LEDOUT;
            end else begin
              axis_idx <= axis_idx + 2'd1;
              state    <= S_READ;
            end
          end
        end
        S_LEDOUT: begin
          sweep_valid <= 1'b1;
          led_out     <= 8'h01 << ((led_hi ^ 8'h80) >> 5);
          gap_cnt     <= GAP_LOAD;
          axis_idx    <= 2'd0;
          state       <= (GAP_LOAD == 16'd0) ? S_READ : S_GAP;
        end
        S_GAP: begin
          gap_cnt <= gap_cnt - 16'd1;
          if (gap_cnt <= 16'd1) state <= S_READ;
        end
        S_HALT: begin
          spi_request <= 1'b0;
          error       <= 1'b1;
          led_out     <= 8'h00;
        end
        default: state <= S_HALT;
      endcase

      if (tmo_hit) begin
        state       <= S_HALT;
        spi_request <= 1'b0;
        error       <= 1'b1;
        err_code    <= 2'd2;
        led_out     <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Self-checking bench for accel_sequencer: behavioural SPI slave plus sensor model.
module tb_accel_sequencer;

  localparam int N_AXES   = 3;
  localparam int POLL_GAP = 16;
  localparam int TIMEOUT  = 64;
  localparam int LED_AXIS = 0;

  logic                 clk_in = 1'b0;
  logic                 nrst = 1'b0;
  logic [31:0]          spi_mosi_data;
  logic [31:0]          spi_miso_data = 32'h0;
  logic [5:0]           spi_nbits;
  logic                 spi_request;
  logic                 spi_ready = 1'b1;
  logic [16*N_AXES-1:0] axis_data;
  logic                 sweep_valid;
  logic                 error;
  logic [1:0]           err_code;
  logic [7:0]           led_out;

  always #5 clk_in = ~clk_in;

  accel_sequencer #(
    .N_AXES(N_AXES), .WHOAMI_VAL(8'h33), .CTRL1_VAL(8'h77), .LED_AXIS(LED_AXIS),
    .POLL_GAP(POLL_GAP), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .nrst(nrst),
    .spi_mosi_data(spi_mosi_data), .spi_miso_data(spi_miso_data),
    .spi_nbits(spi_nbits), .spi_request(spi_request), .spi_ready(spi_ready),
    .axis_data(axis_data), .sweep_valid(sweep_valid),
    .error(error), .err_code(err_code), .led_out(led_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Sensor contents seen by the SPI slave model.
  logic [7:0] whoami_resp = 8'h33;
  logic [7:0] ax_lo[3];
  logic [7:0] ax_hi[3];
  bit         hang = 1'b0;
  bit         slow = 1'b0;

  logic [31:0] log_frame[$];
  logic [5:0]  log_nbits[$];
  logic [7:0]  log_led[$];
  int          log_cyc[$];

  int          cyc = 0;
  int          sweep_cnt = 0;
  int          sweep_cyc = 0;
  int          long_pulse = 0;
  bit          sv_prev = 1'b0;
  logic [47:0] sweep_axis = '0;
  logic [7:0]  sweep_led = '0;

  logic [31:0] m_r;
  logic [31:0] m_resp;
  int          m_a;
  int          m_n;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    sv_prev <= sweep_valid;
    if (sweep_valid && sv_prev) long_pulse <= long_pulse + 1;
    if (sweep_valid) begin
      sweep_cnt  <= sweep_cnt + 1;
      sweep_cyc  <= cyc;
      sweep_axis <= axis_data;
      sweep_led  <= led_out;
    end
  end

  // SPI master model: accepts a request, stays busy a few cycles, returns data.
  always begin
    @(negedge clk_in);
    if (nrst && spi_request && spi_ready) begin
      log_frame.push_back(spi_mosi_data);
      log_nbits.push_back(spi_nbits);
      log_led.push_back(led_out);
      log_cyc.push_back(cyc);
      m_r = $urandom;
      if (spi_nbits == 6'd23) begin
        m_a = int'(spi_mosi_data[23:16] - 8'hE8) / 2;
        m_resp = (m_a >= 0 && m_a < 3) ? {m_r[31:16], ax_lo[m_a], ax_hi[m_a]} : m_r;
      end else if (spi_mosi_data[15:0] == 16'h8F00) begin
        m_resp = {m_r[31:8], whoami_resp};
      end else begin
        m_resp = m_r;
      end
      spi_ready = 1'b0;
      m_n = slow ? 20 : int'($urandom_range(4, 1));
      while (nrst && (hang || m_n > 0)) begin
        @(negedge clk_in);
        m_n--;
      end
      spi_miso_data = m_resp;
      spi_ready     = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k = 0;
    while (log_frame.size() < n && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    check({tag, "_arrived"}, 64'(log_frame.size() >= n), 64'd1);
  endtask

  task automatic check_frame(input int idx, input string tag, input logic [31:0] f,
                             input logic [5:0] nb);
    check({tag, "_frame"}, 64'(log_frame[idx]), 64'(f));
    check({tag, "_nbits"}, 64'(log_nbits[idx]), 64'(nb));
  endtask

  task automatic wait_sweep(input int n);
    int k = 0;
    while (sweep_cnt < n && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    check("sweep_arrived", 64'(sweep_cnt >= n), 64'd1);
  endtask

  // LED level: signed high byte mapped onto eight equal bands, one lit LED.
  function automatic logic [7:0] led_level(input logic [7:0] hi);
    int s;
    s = int'($signed(hi)) + 128;
    return 8'(1 << (s / 32));
  endfunction

  function automatic logic [47:0] exp_axes();
    logic [47:0] v = '0;
    for (int a = 0; a < N_AXES; a++)
      v = v | ((48'(ax_hi[a]) * 48'd256 + 48'(ax_lo[a])) << (16 * a));
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   64'(spi_request), 64'd0);
    check({tag, "_led"},   64'(led_out), 64'hFF);
    check({tag, "_mosi"},  64'(spi_mosi_data), 64'd0);
    check({tag, "_nbits"}, 64'(spi_nbits), 64'd0);
    check({tag, "_axis"},  64'(axis_data), 64'd0);
    check({tag, "_sv"},    64'(sweep_valid), 64'd0);
    check({tag, "_err"},   64'({error, err_code}), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_init[3];
    logic [7:0]  exp_iled[3];
    logic [7:0]  hi_pat[5];
    logic [7:0]  led_const[2];
    int  base;
    int  k;
    int  t;
    bit  found;

    exp_init  = '{32'h2077, 32'h1FC0, 32'h2388};
    exp_iled  = '{8'hFD, 8'hFB, 8'hF7};
    led_const = '{8'h80, 8'h01};
    ax_lo = '{8'h34, 8'h78, 8'hBC};
    ax_hi = '{8'h12, 8'h56, 8'h9A};

    // Reset values
    nrst = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    nrst = 1'b1;

    // Start-up: WHO_AM_I then three init frames with their LED codes
    wait_frames(4, "startup");
    check_frame(0, "whoami", 32'h8F00, 6'd15);
    check("whoami_led", 64'(log_led[0]), 64'hFE);
    for (int i = 0; i < 3; i++) begin
      check_frame(1 + i, $sformatf("init%0d", i), exp_init[i], 6'd15);
      check($sformatf("init%0d_led", i), 64'(log_led[1 + i]), 64'(exp_iled[i]));
    end

    // First sweep with fixed sensor contents
    wait_sweep(1);
    check("sweep1_axes", 64'(sweep_axis), 64'h9ABC_5678_1234);
    check("sweep1_led", 64'(sweep_led), 64'(led_level(8'h12)));
    check("sweep1_frames", 64'(log_frame.size()), 64'd7);
    for (int a = 0; a < 3; a++)
      check_frame(4 + a, $sformatf("read%0d", a), 32'hE80000 + 32'(a) * 32'h20000, 6'd23);

    // Randomized sweeps; first two pin the LED band edges
    hi_pat = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'h00};
    for (int s = 0; s < 5; s++) begin
      for (int a = 0; a < 3; a++) begin
        ax_lo[a] = 8'($urandom);
        ax_hi[a] = 8'($urandom);
      end
      if (s < 2) ax_hi[LED_AXIS] = hi_pat[s];
      if (s == 0) begin
        wait_frames(8, "gap");
        t = log_cyc[7] - sweep_cyc;
        check("gap_len", 64'(t >= POLL_GAP + 1 && t <= POLL_GAP + 2), 64'd1);
      end
      wait_sweep(2 + s);
      check($sformatf("sweep%0d_axes", s + 2), 64'(sweep_axis), 64'(exp_axes()));
      check($sformatf("sweep%0d_led", s + 2), 64'(sweep_led), 64'(led_level(ax_hi[LED_AXIS])));
      if (s < 2) check($sformatf("led_edge%0d", s), 64'(sweep_led), 64'(led_const[s]));
    end

    // Reset during READ_WAIT of axis 1
    slow = 1'b1;
    base = log_frame.size();
    found = 1'b0;
    k = 0;
    while (!found && k < 3000) begin
      @(negedge clk_in);
      k++;
      for (int i = base; i < log_frame.size(); i++)
        if (log_frame[i] == 32'hEA0000) found = 1'b1;
    end
    check("mid_reset_reached", 64'(found), 64'd1);
    @(negedge clk_in);
    nrst = 1'b0;
    @(posedge clk_in);
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk_in);
    slow = 1'b0;
    base = log_frame.size();
    nrst = 1'b1;
    wait_frames(base + 1, "restart");
    check_frame(base, "restart", 32'h8F00, 6'd15);

    // Bad WHO_AM_I halts with code 1 and no further traffic
    whoami_resp = 8'h32;
    nrst = 1'b0;
    repeat (3) @(negedge clk_in);
    base = log_frame.size();
    nrst = 1'b1;
    k = 0;
    while (!error && k < 500) begin
      @(negedge clk_in);
      k++;
    end
    check("badid_error", 64'(error), 64'd1);
    check("badid_code", 64'(err_code), 64'd1);
    repeat (50) @(negedge clk_in);
    check("badid_frames", 64'(log_frame.size()), 64'(base + 1));
    check("badid_req", 64'(spi_request), 64'd0);
    check("badid_led", 64'(led_out), 64'h00);
    check("badid_sticky", 64'(error), 64'd1);

`ifdef SEQ_TIMEOUT_EN
    // Stalled master: halt with code 2 exactly TIMEOUT cycles into the wait
    whoami_resp = 8'h33;
    hang = 1'b1;
    nrst = 1'b0;
    repeat (3) @(negedge clk_in);
    base = log_frame.size();
    nrst = 1'b1;
    wait_frames(base + 1, "tmo_req");
    k = 0;
    while (spi_request && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    t = 0;
    while (!error && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    check("tmo_cycles", 64'(t), 64'(TIMEOUT));
    check("tmo_code", 64'(err_code), 64'd2);
    check("tmo_req_low", 64'(spi_request), 64'd0);
    hang = 1'b0;
`endif

    check("sweep_one_cycle", 64'(long_pulse), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
